// File: rtl/fir_iq_sym_if.sv
// Sample, coefficient and status bundle of the symmetric I/Q FIR decimator.
// The master modport is the sample source and the slave modport is the filter.
interface fir_iq_sym_if #(
  parameter int WIDTH = 24,
  parameter int COEFF = 18,
  parameter int NTAPS = 17
);
  localparam int NU = (NTAPS + 1) / 2;
  localparam int AW = $clog2(NU);

  logic             use_fir;
  logic             in_strobe;
  logic [WIDTH-1:0] in_data_i;
  logic [WIDTH-1:0] in_data_q;
  logic             coeff_we;
  logic [AW-1:0]    coeff_addr;
  logic [COEFF-1:0] coeff_data;
  logic             out_strobe;
  logic [WIDTH-1:0] out_data_i;
  logic [WIDTH-1:0] out_data_q;
  logic             busy;
  logic             overrun;

  modport master (
    output use_fir, in_strobe, in_data_i, in_data_q, coeff_we, coeff_addr, coeff_data,
    input  out_strobe, out_data_i, out_data_q, busy, overrun
  );

  modport slave (
    input  use_fir, in_strobe, in_data_i, in_data_q, coeff_we, coeff_addr, coeff_data,
    output out_strobe, out_data_i, out_data_q, busy, overrun
  );
endinterface

// File: rtl/fir_iq_sym.sv
// Symmetric-folded I/Q FIR decimator: circular sample buffer, one multiplier per
// channel, round-half-up and saturation on output, with a registered bypass path.
module fir_iq_sym #(
  parameter int WIDTH = 24,
  parameter int COEFF = 18,
  parameter int NTAPS = 17,
  parameter int DECIM = 2
) (
  input logic         adc_clk,
  input logic         reset,
  fir_iq_sym_if.slave bus
);
  localparam int NU    = (NTAPS + 1) / 2;
  localparam int AW    = $clog2(NU);
  localparam int PW    = $clog2(NTAPS);
  localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PREW  = WIDTH + 1;
  localparam int PRODW = WIDTH + 1 + COEFF;
  localparam int ACCW  = WIDTH + 1 + COEFF + AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACCW:0] HALF = {{(ACCW - COEFF + 1){1'b0}}, 1'b1, {(COEFF - 1){1'b0}}};

  logic [1:0]              state;
  logic signed [WIDTH-1:0] samp_i [NTAPS];
  logic signed [WIDTH-1:0] samp_q [NTAPS];
  logic signed [COEFF-1:0] coeff  [NU];
  logic [PW-1:0]           wr_ptr, ptr_a, ptr_b;
  logic [DW-1:0]           phase;
  logic [AW-1:0]           step;
  logic signed [ACCW-1:0]  acc_i, acc_q;
  logic [WIDTH-1:0]        out_i, out_q;
  logic                    out_stb, ovr;

  logic                    centre;
  logic signed [PREW-1:0]  pre_i, pre_q;
  logic signed [PRODW-1:0] prod_i, prod_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NTAPS - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(NTAPS - 1) : p - PW'(1);
  endfunction

  // y = (acc + 2^(COEFF-1)) >>> COEFF, clamped when the dropped high bits disagree with the sign.
  function automatic logic [WIDTH-1:0] round_sat(input logic signed [ACCW-1:0] a);
    logic signed [ACCW:0] r;
    r = {a[ACCW-1], a} + HALF;
    if ((&r[ACCW:COEFF+WIDTH-1]) || !(|r[ACCW:COEFF+WIDTH-1]))
      return r[COEFF+WIDTH-1:COEFF];
    else if (r[ACCW])
      return {1'b1, {(WIDTH - 1){1'b0}}};
    else
      return {1'b0, {(WIDTH - 1){1'b1}}};
  endfunction

  // ptr_a walks from the newest sample towards the centre, ptr_b from the oldest;
  // they meet on the centre tap, which is added only once.
  always_comb begin
    centre = (step == AW'(NU - 1));
    pre_i  = PREW'(samp_i[ptr_a]);
    pre_q  = PREW'(samp_q[ptr_a]);
    if (!centre) begin
      pre_i = pre_i + PREW'(samp_i[ptr_b]);
      pre_q = pre_q + PREW'(samp_q[ptr_b]);
    end
    prod_i = PRODW'(pre_i) * PRODW'(coeff[step]);
    prod_q = PRODW'(pre_q) * PRODW'(coeff[step]);
  end

  // NOTE: state uses <= so every register samples the pre-edge value of its neighbours.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      ptr_a   <= '0;
      ptr_b   <= '0;
      phase   <= '0;
      step    <= '0;
      acc_i   <= '0;
      acc_q   <= '0;
      out_i   <= '0;
      out_q   <= '0;
      out_stb <= 1'b0;
      ovr     <= 1'b0;
      // NOTE: buffer and coefficient storage are cleared on reset, so these stay flops rather than RAM.
      for (int n = 0; n < NTAPS; n++) begin
        samp_i[n] <= '0;
        samp_q[n] <= '0;
      end
      for (int k = 0; k < NU; k++) coeff[k] <= '0;
    end else begin
      out_stb <= 1'b0;
      if (bus.coeff_we) coeff[bus.coeff_addr] <= bus.coeff_data;

      if (!bus.use_fir) begin
        state <= S_IDLE;
        phase <= '0;
        if (bus.in_strobe) begin
          out_stb <= 1'b1;
          out_i   <= bus.in_data_i;
          out_q   <= bus.in_data_q;
        end
      end else begin
        if (bus.in_strobe && state != S_IDLE) ovr <= 1'b1;
        case (state)
          S_IDLE: begin
            if (bus.in_strobe) begin
              samp_i[wr_ptr] <= bus.in_data_i;
              samp_q[wr_ptr] <= bus.in_data_q;
              wr_ptr         <= ptr_inc(wr_ptr);
              phase          <= (phase == DW'(DECIM - 1)) ? '0 : phase + DW'(1);
              if (phase == '0) begin
                state <= S_MAC;
                step  <= '0;
                ptr_a <= wr_ptr;
                ptr_b <= ptr_inc(wr_ptr);
                acc_i <= '0;
                acc_q <= '0;
              end
            end
          end
          S_MAC: begin
            acc_i <= acc_i + ACCW'(prod_i);
            acc_q <= acc_q + ACCW'(prod_q);
            ptr_a <= ptr_dec(ptr_a);
            ptr_b <= ptr_inc(ptr_b);
            step  <= step + AW'(1);
            if (centre) state <= S_OUT;
          end
          S_OUT: begin
            out_i   <= round_sat(acc_i);
            out_q   <= round_sat(acc_q);
            out_stb <= 1'b1;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.out_strobe = out_stb;
  assign bus.out_data_i = out_i;
  assign bus.out_data_q = out_q;
  assign bus.busy       = (state != S_IDLE);
  assign bus.overrun    = ovr;
endmodule

// File: tb/tb_fir_iq_sym.sv
// Directed bench for fir_iq_sym: one DECIM=1 instance for filtering, overrun, reset
// and bypass, and one DECIM=2 instance for decimation timing.
module tb_fir_iq_sym;
  localparam int NU  = 9;
  localparam int LAT = NU + 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  fir_iq_sym_if #(.WIDTH(24), .COEFF(18), .NTAPS(17)) bus_a ();
  fir_iq_sym_if #(.WIDTH(24), .COEFF(18), .NTAPS(17)) bus_b ();

  fir_iq_sym #(.WIDTH(24), .COEFF(18), .NTAPS(17), .DECIM(1)) dut_a (
    .adc_clk(clk), .reset(reset), .bus(bus_a.slave));
  fir_iq_sym #(.WIDTH(24), .COEFF(18), .NTAPS(17), .DECIM(2)) dut_b (
    .adc_clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load_all(input logic [17:0] c);
    for (int k = 0; k < NU; k++) begin
      bus_a.coeff_we   = 1'b1;
      bus_a.coeff_addr = 4'(k);
      bus_a.coeff_data = c;
      tick();
    end
    bus_a.coeff_we = 1'b0;
  endtask

  task automatic a_load_one(input int k, input logic [17:0] c);
    bus_a.coeff_we   = 1'b1;
    bus_a.coeff_addr = 4'(k);
    bus_a.coeff_data = c;
    tick();
    bus_a.coeff_we = 1'b0;
  endtask

  // One strobe on bus_a, then wait a bounded number of cycles for its output.
  task automatic a_sample(input logic [23:0] di, input logic [23:0] dq,
                          output logic [23:0] oi, output logic [23:0] oq, output int lat);
    int t0;
    bus_a.in_strobe = 1'b1;
    bus_a.in_data_i = di;
    bus_a.in_data_q = dq;
    t0 = cyc;
    tick();
    bus_a.in_strobe = 1'b0;
    lat = -1;
    oi  = 'x;
    oq  = 'x;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(negedge clk);
      if (bus_a.out_strobe) begin
        lat = cyc - t0;
        oi  = bus_a.out_data_i;
        oq  = bus_a.out_data_q;
      end
    end
    tick();
  endtask

  task automatic impulse_test(input string tag);
    logic [23:0] oi, oq;
    int lat;
    a_load_all(18'h10000);
    for (int n = 0; n < 18; n++) begin
      a_sample((n == 0) ? 24'h100000 : 24'h0, 24'h0, oi, oq, lat);
      check($sformatf("%s_lat%0d", tag, n), 32'(lat), 32'(LAT));
      check($sformatf("%s_i%0d", tag, n), 32'(oi), (n < 17) ? 32'h040000 : 32'h0);
      check($sformatf("%s_q%0d", tag, n), 32'(oq), 32'h0);
    end
  endtask

  initial begin
    logic [23:0] oi, oq;
    int lat, t0, got, seen;

    bus_a.use_fir = 1'b1; bus_a.in_strobe = 1'b0; bus_a.in_data_i = '0; bus_a.in_data_q = '0;
    bus_a.coeff_we = 1'b0; bus_a.coeff_addr = '0; bus_a.coeff_data = '0;
    bus_b.use_fir = 1'b1; bus_b.in_strobe = 1'b0; bus_b.in_data_i = '0; bus_b.in_data_q = '0;
    bus_b.coeff_we = 1'b0; bus_b.coeff_addr = '0; bus_b.coeff_data = '0;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_strobe", 32'(bus_a.out_strobe), 32'h0);
    check("rst_out_i",  32'(bus_a.out_data_i), 32'h0);
    check("rst_out_q",  32'(bus_a.out_data_q), 32'h0);
    check("rst_busy",   32'(bus_a.busy),       32'h0);
    check("rst_ovr",    32'(bus_a.overrun),    32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Test 1: impulse response of 17 equal taps
    impulse_test("imp");

    // Test 2a: rounding on the centre tap alone (c=1 means y = round(x / 2^18))
    a_load_all(18'h0);
    a_load_one(NU - 1, 18'h1);
    for (int n = 0; n < NU; n++) a_sample(24'd131072, 24'd131071, oi, oq, lat);
    check("rnd_half_up_i", 32'(oi), 32'h1);
    check("rnd_below_q",   32'(oq), 32'h0);
    for (int n = 0; n < NU; n++) a_sample(24'hFE0000, 24'd131072, oi, oq, lat);
    check("rnd_neg_half_i", 32'(oi), 32'h0);
    check("rnd_half_up_q",  32'(oq), 32'h1);

    // Test 2b: saturation at both rails
    a_load_all(18'h1FFFF);
    for (int n = 0; n < 17; n++) a_sample(24'h7FFFFF, 24'h800000, oi, oq, lat);
    check("sat_pos_i", 32'(oi), 32'h7FFFFF);
    check("sat_neg_q", 32'(oq), 32'h800000);
    for (int n = 0; n < 17; n++) a_sample(24'h800000, 24'h7FFFFF, oi, oq, lat);
    check("sat_neg_i", 32'(oi), 32'h800000);
    check("sat_pos_q", 32'(oq), 32'h7FFFFF);

    // Test 4: overrun -- second strobe at t0+4 is dropped
    a_load_all(18'h10000);
    for (int n = 0; n < 17; n++) a_sample(24'h0, 24'h0, oi, oq, lat);
    bus_a.in_strobe = 1'b1;
    bus_a.in_data_i = 24'h100000;
    bus_a.in_data_q = 24'h0;
    t0 = cyc;
    tick();
    bus_a.in_strobe = 1'b0;
    tick(); tick(); tick();
    bus_a.in_strobe = 1'b1;
    bus_a.in_data_i = 24'h200000;
    @(negedge clk);
    check("ovr_busy", 32'(bus_a.busy), 32'h1);
    check("ovr_pre",  32'(bus_a.overrun), 32'h0);
    tick();
    bus_a.in_strobe = 1'b0;
    @(negedge clk);
    check("ovr_set", 32'(bus_a.overrun), 32'h1);
    got = -1;
    for (int n = 0; n < 20 && got < 0; n++) begin
      if (bus_a.out_strobe) begin
        got = cyc - t0;
        oi  = bus_a.out_data_i;
      end
      if (got < 0) @(negedge clk);
    end
    check("ovr_lat",   32'(got), 32'(LAT));
    check("ovr_first", 32'(oi),  32'h040000);
    tick();
    a_sample(24'h0, 24'h0, oi, oq, lat);
    check("ovr_dropped", 32'(oi), 32'h040000);
    check("ovr_sticky",  32'(bus_a.overrun), 32'h1);

    // Test 6: reset in the middle of a MAC
    bus_a.in_strobe = 1'b1;
    bus_a.in_data_i = 24'h100000;
    tick();
    bus_a.in_strobe = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus_a.out_strobe) seen++;
    end
    check("rmid_no_strobe", 32'(seen), 32'h0);
    check("rmid_out_i",     32'(bus_a.out_data_i), 32'h0);
    check("rmid_out_q",     32'(bus_a.out_data_q), 32'h0);
    check("rmid_busy",      32'(bus_a.busy),       32'h0);
    check("rmid_ovr",       32'(bus_a.overrun),    32'h0);
    tick();
    impulse_test("imp2");

    // Test 5: bypass
    bus_a.use_fir = 1'b0;
    tick();
    bus_a.in_strobe = 1'b1;
    bus_a.in_data_i = 24'h123456;
    bus_a.in_data_q = 24'hFEDCBA;
    @(negedge clk);
    check("byp_t0_strobe", 32'(bus_a.out_strobe), 32'h0);
    tick();
    bus_a.in_strobe = 1'b0;
    @(negedge clk);
    check("byp_strobe", 32'(bus_a.out_strobe), 32'h1);
    check("byp_i",      32'(bus_a.out_data_i), 32'h123456);
    check("byp_q",      32'(bus_a.out_data_q), 32'hFEDCBA);
    check("byp_busy",   32'(bus_a.busy),       32'h0);
    tick();
    @(negedge clk);
    check("byp_strobe_low", 32'(bus_a.out_strobe), 32'h0);
    check("byp_hold_i",     32'(bus_a.out_data_i), 32'h123456);
    tick();
    bus_a.use_fir = 1'b1;

    // Test 3: DECIM=2 -- outputs only after samples 1, 3, 5
    for (int k = 0; k < NU; k++) begin
      bus_b.coeff_we   = 1'b1;
      bus_b.coeff_addr = 4'(k);
      bus_b.coeff_data = 18'h10000;
      tick();
    end
    bus_b.coeff_we = 1'b0;
    for (int s = 0; s < 6; s++) begin
      bus_b.in_strobe = 1'b1;
      bus_b.in_data_i = (s == 0) ? 24'h100000 : 24'h0;
      bus_b.in_data_q = 24'h0;
      t0 = cyc;
      tick();
      bus_b.in_strobe = 1'b0;
      got = -1;
      oi  = 'x;
      for (int n = 0; n < 19; n++) begin
        @(negedge clk);
        if (bus_b.out_strobe && got < 0) begin
          got = cyc - t0;
          oi  = bus_b.out_data_i;
        end
      end
      check($sformatf("dec_lat%0d", s + 1), 32'(got), (s % 2 == 0) ? 32'(LAT) : 32'hFFFF_FFFF);
      if (s % 2 == 0)
        check($sformatf("dec_i%0d", s + 1), 32'(oi), 32'h040000);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
